// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector:
// state encodings plus a small width helper.
package seq_serializer_pkg;

  // Serializer FSM encodings; 2-bit so illegal codes exist and can be recovered from.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } ser_state_t;

  // Detector FSM encodings (1001 detector), kept here so both blocks agree.
  typedef enum logic [1:0] {
    DET_S0   = 2'b00,
    DET_S1   = 2'b01,
    DET_S10  = 2'b10,
    DET_S100 = 2'b11
  } det_state_t;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words on a valid/ready
// handshake and shifts them out one bit per clock on x. A one-word holding
// buffer lets the next word follow the current one with no idle bit.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;   // bits remaining after the one on x

  logic             accept;
  logic [WIDTH-1:0] shreg_shifted;

  // Ready depends only on buffer occupancy, never on in_valid.
  assign in_ready = ~buf_full_q;
  assign accept   = in_valid & ~buf_full_q;

  // Move the next bit into the output position.
  always_comb begin
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: load, shift, buffer, and end-of-word hand-off.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = in_data;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q - CW'(1);
          if (accept) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
          end
        end else if (buf_full_q) begin
          // Buffered word takes over; in_ready was low so no accept this edge.
          shreg_d    = buf_q;
          cnt_d      = CNT_LAST;
          buf_full_d = 1'b0;
        end else if (accept) begin
          // Bypass straight into the shift register, buffer stays empty.
          shreg_d = in_data;
          cnt_d   = CNT_LAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        buf_full_d = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      cnt_q      <= cnt_d;
    end
  end

  // Serial outputs come from registered state only.
  always_comb begin
    x         = IDLE_BIT;
    x_valid   = 1'b0;
    word_done = 1'b0;
    if (state_q == ST_SHIFT) begin
      x         = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      x_valid   = 1'b1;
      word_done = (cnt_q == '0);
    end
    busy = (state_q == ST_SHIFT) | buf_full_q;
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an MSB-first and an LSB-first instance share one
// input stream; a word-queue model predicts every output every cycle.
module tb_seq_serializer;

  logic       clk;
  logic       res_n;
  logic [7:0] in_data;
  logic       in_valid;

  logic rdy_m, x_m, xv_m, wd_m, busy_m;
  logic rdy_l, x_l, xv_l, wd_l, busy_l;

  int n_cmp;
  int n_err;
  int xv_seen;

  // Model: words in flight (front is on x) and bit position within the front word.
  logic [7:0] q[$];
  int         pos;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .res_n(res_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .x(x_m), .x_valid(xv_m), .word_done(wd_m), .busy(busy_m)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .res_n(res_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .x(x_l), .x_valid(xv_l), .word_done(wd_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs of both instances against the word-queue model.
  task automatic check_all();
    logic [7:0] w;
    logic       act;
    logic       e_xm, e_xl, e_wd;
    act  = (q.size() > 0);
    w    = act ? q[0] : 8'h00;
    e_xm = act ? w[7 - pos] : 1'b0;
    e_xl = act ? w[pos] : 1'b0;
    e_wd = act && (pos == 7);
    chk("x_msb", x_m, e_xm);
    chk("x_lsb", x_l, e_xl);
    chk("xvalid_msb", xv_m, act);
    chk("xvalid_lsb", xv_l, act);
    chk("wdone_msb", wd_m, e_wd);
    chk("wdone_lsb", wd_l, e_wd);
    chk("busy_msb", busy_m, act);
    chk("busy_lsb", busy_l, act);
    chk("ready_msb", rdy_m, q.size() < 2);
    chk("ready_lsb", rdy_l, q.size() < 2);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic tick(input logic v, input logic [7:0] d, output bit acc);
    in_valid = v;
    in_data  = d;
    acc = v && (q.size() < 2);
    @(posedge clk);
    if (q.size() > 0) begin
      pos++;
      if (pos == 8) begin
        q.delete(0);
        pos = 0;
      end
    end
    if (acc) begin
      q.push_back(d);
      $display("accept word=%02h inflight=%0d t=%0t", d, q.size(), $time);
    end
    @(negedge clk);
    if (xv_m) xv_seen++;
    check_all();
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 40 && q.size() > 0; k++) tick(1'b0, 8'h00, acc);
    chk("drain_empty", q.size(), 0);
    tick(1'b0, 8'h00, acc);
  endtask

  // Send one word from idle and collect the serial bits seen on both outputs.
  task automatic send_collect(input logic [7:0] w, input logic [7:0] em,
                              input logic [7:0] el, input string tag);
    bit acc;
    logic [7:0] gm, gl;
    tick(1'b1, w, acc);
    chk({tag, "_accept"}, acc, 1'b1);
    gm = {7'd0, x_m};
    gl = {7'd0, x_l};
    for (int k = 0; k < 7; k++) begin
      tick(1'b0, 8'h00, acc);
      gm = {gm[6:0], x_m};
      gl = {gl[6:0], x_l};
    end
    chk({tag, "_bits_msb"}, gm, em);
    chk({tag, "_bits_lsb"}, gl, el);
    drain();
  endtask

  initial begin
    bit         acc;
    bit         pend;
    logic       v;
    logic [7:0] d;
    logic [7:0] words3 [3];
    int         idx;
    int         base;
    int         nwords;

    n_cmp = 0; n_err = 0; xv_seen = 0; pos = 0;
    res_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    check_all();
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
    check_all();

    // 1/2: single word, both bit orders
    send_collect(8'h96, 8'h96, 8'h69, "t1");

    // 3: back-to-back with valid held
    words3[0] = 8'hA5; words3[1] = 8'h3C; words3[2] = 8'hFF;
    idx = 0;
    base = xv_seen;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      tick(1'b1, words3[idx], acc);
      if (acc) idx++;
    end
    chk("t3_accepted", idx, 3);
    in_valid = 1'b0;
    drain();
    chk("t3_xvalid_cycles", xv_seen - base, 24);

    // 4: second word offered exactly in the word_done cycle
    tick(1'b1, 8'hC3, acc);
    for (int k = 0; k < 7; k++) tick(1'b0, 8'h00, acc);
    chk("t4_wdone_cycle", wd_m, 1'b1);
    tick(1'b1, 8'h5A, acc);
    chk("t4_bypass_accept", acc, 1'b1);
    chk("t4_no_gap", xv_m, 1'b1);
    drain();

    // 5: asynchronous reset mid-word
    tick(1'b1, 8'hF0, acc);
    for (int k = 0; k < 3; k++) tick(1'b0, 8'h00, acc);
    #2 res_n = 1'b0;
    #1;
    q.delete();
    pos = 0;
    chk("t5_async_x", x_m, 1'b0);
    chk("t5_async_xvalid", xv_m, 1'b0);
    chk("t5_async_ready", rdy_m, 1'b1);
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    res_n = 1'b1;
    @(negedge clk);
    check_all();
    send_collect(8'h01, 8'h01, 8'h80, "t5");

    // 6: random valid/ready stress
    base = xv_seen;
    nwords = 0;
    pend = 1'b0;
    v = 1'b0;
    d = 8'h00;
    for (int k = 0; k < 20000 && nwords < 1000; k++) begin
      if (!pend) begin
        v = ($urandom_range(0, 9) < 7);
        d = 8'($urandom);
      end
      tick(v, d, acc);
      if (acc) begin
        nwords++;
        pend = 1'b0;
      end else begin
        pend = v;
      end
    end
    in_valid = 1'b0;
    drain();
    chk("t6_words", nwords, 1000);
    chk("t6_xvalid_cycles", xv_seen - base, 8 * nwords);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
